// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl -- retirement sequencer for the 32-entry reorder buffer.
//
// Each cycle it inspects the ROB head and decides whether the head retires.
// A retiring head is popped (commit) and, where it has a real destination, is
// written to the register file on the same cycle. Store heads are held in
// ST_WAIT until the LSU acknowledges them. A mispredicted branch or jump
// retires and then sequences a FLUSH_CYCLES-long flush with a one-cycle fetch
// redirect.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   head_*            ROB head entry: valid/done, index, dest reg, value,
//                     type flags, mispredict flag, correct target PC
//   st_ack            LSU has performed the head store
//   commit            pop the ROB head this cycle (combinational)
//   rf_valid, rf_*    regfile write strobe and data/tag/dest (combinational)
//   st_commit         release head store to the LSU, held until st_ack
//   flush             squash ROB, RS, LSQ and RAT tags
//   redirect_valid/pc one-cycle fetch redirect and its target
//   dispatch_stall    block issue into the ROB
//   commit_count      retired-instruction counter, wraps modulo 2^32
module rob_commit_ctrl #(
   parameter int ROB_IDX_W    = 5,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 head_valid,
   input  logic                 head_done,
   input  logic [ROB_IDX_W-1:0] head_idx,
   input  logic [4:0]           head_dr,
   input  logic [31:0]          head_value,
   input  logic                 head_is_st,
   input  logic                 head_is_br,
   input  logic                 head_is_jump,
   input  logic                 head_mispredict,
   input  logic [31:0]          head_target_pc,
   input  logic                 st_ack,
   output logic                 commit,
   output logic                 rf_valid,
   output logic [31:0]          rf_value,
   output logic [ROB_IDX_W-1:0] rf_rob_idx,
   output logic [4:0]           rf_regfile_idx,
   output logic                 st_commit,
   output logic                 flush,
   output logic                 redirect_valid,
   output logic [31:0]          redirect_pc,
   output logic                 dispatch_stall,
   output logic [31:0]          commit_count
);

   localparam logic [1:0] S_RUN     = 2'd0;
   localparam logic [1:0] S_ST_WAIT = 2'd1;
   localparam logic [1:0] S_FLUSH   = 2'd2;

   localparam int              CNT_W    = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      redirect_pc_q, redirect_pc_d;
   logic [31:0]      commit_count_q, commit_count_d;
   logic             commit_int;
   logic             rf_valid_int;
   logic             head_ready;
   logic             head_mp;

   assign head_ready = head_valid & head_done;
   assign head_mp    = (head_is_br | head_is_jump) & head_mispredict;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      redirect_pc_d = redirect_pc_q;
      commit_int    = 1'b0;
      rf_valid_int  = 1'b0;
      case (state_q)
         S_RUN: begin
            if (head_ready) begin
               if (head_is_st) begin
                  state_d = S_ST_WAIT;
               end else begin
                  commit_int   = 1'b1;
                  // Branches never write; jumps (even mispredicted) write the link.
                  rf_valid_int = !head_is_br && (head_dr != 5'd0);
                  if (head_mp) begin
                     state_d       = S_FLUSH;
                     cnt_d         = CNT_LOAD;
                     redirect_pc_d = head_target_pc;
                  end
               end
            end
         end
         S_ST_WAIT: begin
            if (st_ack) begin
               commit_int = 1'b1;
               state_d    = S_RUN;
            end
         end
         S_FLUSH: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
      commit_count_d = commit_count_q + (commit_int ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_RUN;
         cnt_q          <= '0;
         redirect_pc_q  <= '0;
         commit_count_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         redirect_pc_q  <= redirect_pc_d;
         commit_count_q <= commit_count_d;
      end
   end

   // Every output is forced to zero while rst is asserted, including the
   // registered ones whose state has not yet been cleared by the reset edge.
   assign commit         = ~rst & commit_int;
   assign rf_valid       = ~rst & rf_valid_int;
   assign rf_value       = rst ? '0 : head_value;
   assign rf_rob_idx     = rst ? '0 : head_idx;
   assign rf_regfile_idx = rst ? '0 : head_dr;
   assign st_commit      = ~rst & (state_q == S_ST_WAIT);
   assign flush          = ~rst & (state_q == S_FLUSH);
   assign dispatch_stall = ~rst & (state_q == S_FLUSH);
   // Counter still holds its load value only in the first flush cycle.
   assign redirect_valid = ~rst & (state_q == S_FLUSH) & (cnt_q == CNT_LOAD);
   assign redirect_pc    = rst ? '0 : redirect_pc_q;
   assign commit_count   = rst ? '0 : commit_count_q;

endmodule
